// File: rtl/dlt_sig_dac_multi.sv
// Multi-channel 1st/2nd order delta-sigma DAC with linear ramp toward each new frame.
// One-deep frame buffer: ready is registered !pend; a pending frame loads when the ramp is idle or on its last cycle.
module dlt_sig_dac_multi #(
    parameter int NUM_CH       = 2,
    parameter int SAMPLE_W     = 16,
    parameter int INTERP_SHIFT = 4,
    parameter int DITHER_SHIFT = 0,
    parameter int MIN_OFF      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH*SAMPLE_W-1:0] sample_data,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    input  logic                       order_sel,
    input  logic                       dither_en,
    output logic [NUM_CH*SAMPLE_W-1:0] cur_sample,
    output logic                       busy,
    output logic [NUM_CH-1:0]          audio_out
);
    localparam int ACC_W = SAMPLE_W + 8;
    localparam int SUM_W = ACC_W + 2;
    localparam int CUR_W = SAMPLE_W + 2;
    localparam int STP_W = SAMPLE_W + 1;
    localparam int DIF_W = 21;
    localparam int CNT_W = (INTERP_SHIFT > 0) ? INTERP_SHIFT : 1;

    localparam logic signed [SUM_W-1:0] FS     = SUM_W'(1) <<< (SAMPLE_W + 1);
    localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(1) <<< (ACC_W - 2);
    localparam logic signed [SUM_W-1:0] SAT_LO = -SAT_HI;
    localparam logic signed [CUR_W-1:0] CUR_HI = (CUR_W'(1) <<< (SAMPLE_W - 1)) - CUR_W'(1);
    localparam logic signed [CUR_W-1:0] CUR_LO = -CUR_HI - CUR_W'(1);

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
        if (v > SAT_HI)      return SAT_HI[ACC_W-1:0];
        else if (v < SAT_LO) return SAT_LO[ACC_W-1:0];
        else                 return v[ACC_W-1:0];
    endfunction

    // Floor-rounded negative steps can overshoot by a few LSBs; clamp instead of wrapping.
    function automatic logic signed [SAMPLE_W-1:0] sat_cur(input logic signed [CUR_W-1:0] v);
        if (v > CUR_HI)      return CUR_HI[SAMPLE_W-1:0];
        else if (v < CUR_LO) return CUR_LO[SAMPLE_W-1:0];
        else                 return v[SAMPLE_W-1:0];
    endfunction

    function automatic logic signed [19:0] rotl20(input logic [19:0] v, input int s);
        logic [39:0] w;
        w = {v, v} << (s % 20);
        return w[39:20];
    endfunction

    logic                        pend_q, pend_d, rdy_q, rdy_d, ramp_q, ramp_d, order_q, order_d;
    logic [NUM_CH*SAMPLE_W-1:0]  pend_dat_q, pend_dat_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic signed [SAMPLE_W-1:0]  cur_q [NUM_CH];
    logic signed [SAMPLE_W-1:0]  cur_d [NUM_CH];
    logic signed [SAMPLE_W-1:0]  tgt_q [NUM_CH];
    logic signed [SAMPLE_W-1:0]  tgt_d [NUM_CH];
    logic signed [STP_W-1:0]     step_q [NUM_CH];
    logic signed [STP_W-1:0]     step_d [NUM_CH];
    logic signed [19:0]          nprev_q [NUM_CH];
    logic signed [19:0]          nprev_d [NUM_CH];
    logic signed [ACC_W-1:0]     a_q [NUM_CH];
    logic signed [ACC_W-1:0]     a_d [NUM_CH];
    logic signed [ACC_W-1:0]     b_q [NUM_CH];
    logic signed [ACC_W-1:0]     b_d [NUM_CH];
    logic [23:0]                 lfsr_q, lfsr_d;
    logic [NUM_CH-1:0]           out_q, out_d;
    logic                        load;

    assign load = pend_q && (!ramp_q || cnt_q == '0);

    always_comb begin : interp
        logic signed [SAMPLE_W-1:0] base;
        logic signed [SAMPLE_W-1:0] nw;
        base       = '0;
        nw         = '0;
        pend_d     = pend_q;
        pend_dat_d = pend_dat_q;
        ramp_d     = ramp_q;
        cnt_d      = cnt_q;
        cur_d      = cur_q;
        tgt_d      = tgt_q;
        step_d     = step_q;
        if (ramp_q) begin
            if (cnt_q == '0) begin
                ramp_d = 1'b0;
                cur_d  = tgt_q;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
                for (int k = 0; k < NUM_CH; k++)
                    cur_d[k] = sat_cur(CUR_W'(cur_q[k]) + CUR_W'(step_q[k]));
            end
        end
        if (sample_valid && rdy_q) begin
            pend_d     = 1'b1;
            pend_dat_d = sample_data;
        end
        // On the last ramp cycle the new ramp starts from the exact old target.
        if (load) begin
            pend_d = 1'b0;
            ramp_d = (INTERP_SHIFT > 0);
            cnt_d  = '1;
            for (int k = 0; k < NUM_CH; k++) begin
                base      = ramp_q ? tgt_q[k] : cur_q[k];
                nw        = pend_dat_q[k*SAMPLE_W +: SAMPLE_W];
                tgt_d[k]  = nw;
                cur_d[k]  = (INTERP_SHIFT > 0) ? base : nw;
                step_d[k] = (STP_W'(nw) - STP_W'(base)) >>> INTERP_SHIFT;
            end
        end
        rdy_d = !pend_d;
    end

    always_comb begin : dsm
        logic signed [19:0]      n;
        logic signed [DIF_W-1:0] dif;
        logic signed [SUM_W-1:0] x, fb, dv, an;
        n       = '0;
        dif     = '0;
        x       = '0;
        fb      = '0;
        dv      = '0;
        an      = '0;
        lfsr_d  = {1'b0, lfsr_q[23:1]} ^ (lfsr_q[0] ? 24'hE10000 : 24'h000000);
        order_d = order_sel;
        a_d     = a_q;
        b_d     = b_q;
        nprev_d = nprev_q;
        out_d   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            n          = rotl20(lfsr_q[19:0], 5 * k);
            nprev_d[k] = n;
            dif        = DIF_W'(n) - DIF_W'(nprev_q[k]);
            dv         = dither_en ? SUM_W'(dif >>> DITHER_SHIFT) : '0;
            x          = SUM_W'(cur_q[k]);
            x          = x + (x <<< 1);
            fb         = out_q[k] ? FS : -FS;
            if (order_q) begin
                a_d[k]   = sat_acc(SUM_W'(a_q[k]) + x - fb);
                an       = SUM_W'(a_d[k]);
                b_d[k]   = sat_acc(SUM_W'(b_q[k]) + an - fb + dv);
                out_d[k] = (b_d[k] >= 0) && !((MIN_OFF != 0) && out_q[k]);
            end else begin
                a_d[k]   = sat_acc(SUM_W'(a_q[k]) + x - fb + dv);
                out_d[k] = (a_d[k] >= 0);
            end
            // Loop order switch: restart both integrators from zero with the output held low.
            if (order_sel != order_q) begin
                a_d[k]   = '0;
                b_d[k]   = '0;
                out_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= 1'b0;
            pend_dat_q <= '0;
            rdy_q      <= 1'b0;
            ramp_q     <= 1'b0;
            cnt_q      <= '0;
            lfsr_q     <= 24'hFFFFFF;
            order_q    <= 1'b0;
            out_q      <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                cur_q[k]   <= '0;
                tgt_q[k]   <= '0;
                step_q[k]  <= '0;
                nprev_q[k] <= '0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
            end
        end else begin
            pend_q     <= pend_d;
            pend_dat_q <= pend_dat_d;
            rdy_q      <= rdy_d;
            ramp_q     <= ramp_d;
            cnt_q      <= cnt_d;
            lfsr_q     <= lfsr_d;
            order_q    <= order_d;
            out_q      <= out_d;
            cur_q      <= cur_d;
            tgt_q      <= tgt_d;
            step_q     <= step_d;
            nprev_q    <= nprev_d;
            a_q        <= a_d;
            b_q        <= b_d;
        end
    end

    assign sample_ready = rdy_q;
    assign busy         = ramp_q || pend_q;
    assign audio_out    = out_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cur
        assign cur_sample[g*SAMPLE_W +: SAMPLE_W] = cur_q[g];
    end
endmodule

// File: tb/tb_dlt_sig_dac_multi.sv
// Directed bench for dlt_sig_dac_multi: reset, handshake/ramp timing, and pulse densities.
module tb_dlt_sig_dac_multi;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] sample_data;
    logic        sample_valid;
    logic        order_sel;
    logic        dither_en;
    logic        sample_ready, busy;
    logic [31:0] cur_sample;
    logic [1:0]  audio_out;
    logic        mo_ready, mo_busy;
    logic [31:0] mo_cur;
    logic [1:0]  mo_audio;

    int    n_chk  = 0;
    int    n_fail = 0;
    longint bmax;
    int    mo_pairs;
    logic [1:0] mo_prev;

    always #5 clk = ~clk;

    dlt_sig_dac_multi dut (
        .clk(clk), .rst(rst), .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .order_sel(order_sel), .dither_en(dither_en),
        .cur_sample(cur_sample), .busy(busy), .audio_out(audio_out)
    );

    dlt_sig_dac_multi #(.MIN_OFF(1)) dut_mo (
        .clk(clk), .rst(rst), .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(mo_ready), .order_sel(order_sel), .dither_en(dither_en),
        .cur_sample(mo_cur), .busy(mo_busy), .audio_out(mo_audio)
    );

    task automatic check(input string tag, input longint obs, input longint exp, input longint tol = 0);
        n_chk++;
        if (obs < exp - tol || obs > exp + tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (+/-%0d)", tag, obs, exp, tol);
        end
    endtask

    function automatic longint absl(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic send(input logic [31:0] f);
        bit ok;
        ok = 1'b0;
        sample_data  = f;
        sample_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (sample_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        sample_valid = 1'b0;
        check("send_accepted", longint'(ok), 1);
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while (busy && i < 200) begin
            @(negedge clk);
            i++;
        end
        check(tag, longint'(busy), 0);
    endtask

    task automatic run_count(input int n, output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            c0 += int'(audio_out[0]);
            c1 += int'(audio_out[1]);
            if (mo_audio[0] && mo_prev[0]) mo_pairs++;
            if (mo_audio[1] && mo_prev[1]) mo_pairs++;
            mo_prev = mo_audio;
            if (absl(longint'(dut.b_q[0]))    > bmax) bmax = absl(longint'(dut.b_q[0]));
            if (absl(longint'(dut.b_q[1]))    > bmax) bmax = absl(longint'(dut.b_q[1]));
            if (absl(longint'(dut_mo.b_q[0])) > bmax) bmax = absl(longint'(dut_mo.b_q[0]));
            if (absl(longint'(dut_mo.b_q[1])) > bmax) bmax = absl(longint'(dut_mo.b_q[1]));
        end
    endtask

    initial begin
        int c0, c1;
        longint e0;
        rst          = 1'b1;
        sample_data  = '0;
        sample_valid = 1'b0;
        order_sel    = 1'b0;
        dither_en    = 1'b0;
        bmax         = 0;
        mo_pairs     = 0;
        mo_prev      = '0;

        // Reset held for 3 edges.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_audio", longint'(audio_out), 0);
        check("rst_ready", longint'(sample_ready), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_cur", longint'(cur_sample), 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_ready", longint'(sample_ready), 1);
        check("post_rst_busy", longint'(busy), 0);

        // Zero input, 1st order: output alternates, half density.
        send({16'd0, 16'd0});
        wait_idle("t2_idle");
        run_count(4096, c0, c1);
        check("t2_ones_ch0", c0, 2048, 2);
        check("t2_ones_ch1", c1, 2048, 2);

        // Full scale: duty 0.875 / 0.125.
        send({16'h8000, 16'h7FFF});
        wait_idle("t3_idle");
        run_count(8192, c0, c1);
        check("t3_ones_ch0", c0, 7168, 4);
        check("t3_ones_ch1", c1, 1024, 4);

        // Ramp timing: 0 -> 1600 (step 100), second frame queued, back-to-back ramp to 0.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t4_ready_start", longint'(sample_ready), 1);
        check("t4_cur_start", longint'(cur_sample), 0);
        sample_data  = {16'hF9C0, 16'd1600};
        sample_valid = 1'b1;
        for (int j = 0; j <= 33; j++) begin
            @(negedge clk);
            if (j == 0)
                sample_valid = 1'b0;
            if (j <= 1)       e0 = 0;
            else if (j <= 17) e0 = 100 * (j - 1);
            else              e0 = 1600 - 100 * (j - 17);
            check($sformatf("t4_cur0_%0d", j), longint'($signed(cur_sample[15:0])), e0);
            check($sformatf("t4_cur1_%0d", j), longint'($signed(cur_sample[31:16])), -e0);
            check($sformatf("t4_ready_%0d", j), longint'(sample_ready),
                  (j == 0 || (j >= 3 && j <= 16)) ? 0 : 1);
            check($sformatf("t4_busy_%0d", j), longint'(busy), (j <= 32) ? 1 : 0);
            if (j == 2) begin
                sample_data  = '0;
                sample_valid = 1'b1;
            end
            if (j == 3)
                sample_valid = 1'b0;
        end

        // 2nd order with dither: duty 0.875 / 0.125 within 0.005; MIN_OFF copy never outputs 11.
        send({16'h8000, 16'h7FFF});
        wait_idle("t5_idle");
        order_sel = 1'b1;
        dither_en = 1'b1;
        @(negedge clk);
        check("t5_switch_audio", longint'(audio_out), 0);
        check("t5_switch_b0", longint'(dut.b_q[0]), 0);
        bmax     = 0;
        mo_pairs = 0;
        mo_prev  = '0;
        run_count(65536, c0, c1);
        check("t5_ones_ch0", c0, 57344, 327);
        check("t5_ones_ch1", c1, 8192, 327);
        check("t5_b_bound", bmax, 0, 4194304);
        check("t5_minoff_11", mo_pairs, 0);

        // Switch back to 1st order mid-stream.
        order_sel = 1'b0;
        dither_en = 1'b0;
        @(negedge clk);
        check("t6_switch_audio", longint'(audio_out), 0);
        check("t6_switch_a0", longint'(dut.a_q[0]), 0);
        check("t6_switch_a1", longint'(dut.a_q[1]), 0);
        check("t6_switch_b1", longint'(dut.b_q[1]), 0);
        run_count(4096, c0, c1);
        check("t6_ones_ch0", c0, 3584, 4);
        check("t6_ones_ch1", c1, 512, 4);
        order_sel = 1'b1;
        @(negedge clk);
        check("t6_reswitch_audio", longint'(audio_out), 0);
        check("t6_reswitch_a0", longint'(dut.a_q[0]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
